// File: rtl/inspectable_read_sequencer.sv
// Walks a variable's elements and flits through the inspectable chain one request at a time,
// handling retries and timeouts, and streams each response value out over ready/valid.
module inspectable_read_sequencer #(
  parameter int unsigned MAX_RETRIES    = 15,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_variable_index_i,
  input  logic [15:0] cmd_element_count_i,
  output logic        chain_req_valid_o,
  output logic [63:0] chain_req_o,
  input  logic        chain_rsp_valid_i,
  input  logic [63:0] chain_rsp_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_data_o,
  output logic [15:0] out_element_index_o,
  output logic [11:0] out_flit_index_o,
  output logic        out_last_flit_o,
  output logic        out_last_element_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef struct packed {
    logic        valid;
    logic        retry;
    logic        last_flit;
    logic        last_element;
    logic [15:0] variable_index;
    logic [15:0] element_index;
    logic [11:0] flit_index;
    logic [15:0] value;
  } iv_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_e;

  state_e        state_q, state_d;
  logic [15:0]   var_q, var_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   elem_q, elem_d;
  logic [11:0]   flit_q, flit_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   data_q, data_d;
  logic          lf_q, lf_d;
  logic          le_q, le_d;
  logic          error_q, error_d;

  iv_t  rsp;
  iv_t  req;
  logic rsp_match;
  logic last_elem;

  assign rsp       = iv_t'(chain_rsp_i);
  assign rsp_match = chain_rsp_valid_i && rsp.valid && (rsp.variable_index == var_q) &&
                     (rsp.element_index == elem_q) && (rsp.flit_index == flit_q);
  assign last_elem = ({1'b0, elem_q} + 17'd1) == {1'b0, count_q};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      var_q   <= '0;
      count_q <= '0;
      elem_q  <= '0;
      flit_q  <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      lf_q    <= 1'b0;
      le_q    <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      var_q   <= var_d;
      count_q <= count_d;
      elem_q  <= elem_d;
      flit_q  <= flit_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      lf_q    <= lf_d;
      le_q    <= le_d;
      error_q <= error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    var_d   = var_q;
    count_d = count_q;
    elem_d  = elem_q;
    flit_d  = flit_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    lf_d    = lf_q;
    le_d    = le_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          var_d   = cmd_variable_index_i;
          count_d = cmd_element_count_i;
          elem_d  = '0;
          flit_d  = '0;
          retry_d = '0;
          error_d = 1'b0;
          state_d = (cmd_element_count_i == 16'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A matching response wins over a timeout expiring in the same cycle
        if (rsp_match) begin
          if (rsp.retry) begin
            if (retry_q == RW'(MAX_RETRIES)) begin
              error_d = 1'b1;
              state_d = DONE;
            end else begin
              retry_d = retry_q + RW'(1);
              state_d = ISSUE;
            end
          end else begin
            data_d  = rsp.value;
            lf_d    = rsp.last_flit;
            le_d    = rsp.last_element;
            state_d = EMIT;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          if (!lf_q) begin
            if (flit_q == 12'hFFF) begin
              error_d = 1'b1;
              state_d = DONE;
            end else begin
              flit_d  = flit_q + 12'd1;
              retry_d = '0;
              state_d = ISSUE;
            end
          end else if (le_q || last_elem) begin
            state_d = DONE;
          end else begin
            elem_d  = elem_q + 16'd1;
            flit_d  = '0;
            retry_d = '0;
            state_d = ISSUE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    req                = '0;
    req.variable_index = var_q;
    req.element_index  = elem_q;
    req.flit_index     = flit_q;
    cmd_ready_o         = (state_q == IDLE);
    chain_req_valid_o   = (state_q == ISSUE);
    chain_req_o         = (state_q == ISSUE) ? 64'(req) : 64'd0;
    out_valid_o         = (state_q == EMIT);
    out_data_o          = data_q;
    out_element_index_o = elem_q;
    out_flit_index_o    = flit_q;
    out_last_flit_o     = lf_q;
    out_last_element_o  = le_q;
    done_o              = (state_q == DONE);
    error_o             = error_q;
  end

endmodule

// File: tb/tb_inspectable_read_sequencer.sv
// Directed bench for inspectable_read_sequencer: scalar, multi-flit, retry, timeout, reset and empty reads.
module tb_inspectable_read_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_variable_index_i;
  logic [15:0] cmd_element_count_i;
  logic        chain_req_valid_o;
  logic [63:0] chain_req_o;
  logic        chain_rsp_valid_i;
  logic [63:0] chain_rsp_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic [15:0] out_element_index_o;
  logic [11:0] out_flit_index_o;
  logic        out_last_flit_o;
  logic        out_last_element_o;
  logic        done_o;
  logic        error_o;

  int vectors     = 0;
  int miscompares = 0;

  inspectable_read_sequencer #(.MAX_RETRIES(3), .TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid_i          (cmd_valid_i),
    .cmd_ready_o          (cmd_ready_o),
    .cmd_variable_index_i (cmd_variable_index_i),
    .cmd_element_count_i  (cmd_element_count_i),
    .chain_req_valid_o    (chain_req_valid_o),
    .chain_req_o          (chain_req_o),
    .chain_rsp_valid_i    (chain_rsp_valid_i),
    .chain_rsp_i          (chain_rsp_i),
    .out_valid_o          (out_valid_o),
    .out_ready_i          (out_ready_i),
    .out_data_o           (out_data_o),
    .out_element_index_o  (out_element_index_o),
    .out_flit_index_o     (out_flit_index_o),
    .out_last_flit_o      (out_last_flit_o),
    .out_last_element_o   (out_last_element_o),
    .done_o               (done_o),
    .error_o              (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Layout MSB..LSB: valid, retry, last_flit, last_element, var[16], elem[16], flit[12], value[16]
  function automatic logic [63:0] iv(input logic vld, input logic rty, input logic lf, input logic le,
                                     input logic [15:0] v, input logic [15:0] e,
                                     input logic [11:0] f, input logic [15:0] val);
    return {vld, rty, lf, le, v, e, f, val};
  endfunction

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] v, input logic [15:0] cnt);
    cmd_valid_i          = 1'b1;
    cmd_variable_index_i = v;
    cmd_element_count_i  = cnt;
    check_vec("cmd_ready", 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  // Waits (bounded) for the request, checks it, then answers with one matching response
  task automatic serve(input logic [15:0] v, input logic [15:0] e, input logic [11:0] f,
                       input logic rty, input logic lf, input logic le, input logic [15:0] val);
    for (int i = 0; i < 20 && !chain_req_valid_o; i++) tick();
    check_vec("req_valid", 64'(chain_req_valid_o), 64'd1);
    check_vec("req_fields", chain_req_o, iv(1'b0, 1'b0, 1'b0, 1'b0, v, e, f, 16'h0));
    tick();
    check_vec("req_one_cycle", 64'(chain_req_valid_o), 64'd0);
    chain_rsp_valid_i = 1'b1;
    chain_rsp_i       = iv(1'b1, rty, lf, le, v, e, f, val);
    tick();
    chain_rsp_valid_i = 1'b0;
    chain_rsp_i       = '0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] val, input logic [15:0] e,
                           input logic [11:0] f, input logic lf, input logic le);
    check_vec({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    check_vec({tag, "_data"}, 64'(out_data_o), 64'(val));
    check_vec({tag, "_elem"}, 64'(out_element_index_o), 64'(e));
    check_vec({tag, "_flit"}, 64'(out_flit_index_o), 64'(f));
    check_vec({tag, "_lflags"}, {62'd0, out_last_flit_o, out_last_element_o}, {62'd0, lf, le});
  endtask

  task automatic scalar_read(input logic [15:0] v, input logic [15:0] val);
    send_cmd(v, 16'd1);
    serve(v, 16'd0, 12'd0, 1'b0, 1'b1, 1'b1, val);
    check_out("scalar", val, 16'd0, 12'd0, 1'b1, 1'b1);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check_vec("scalar_done", 64'(done_o), 64'd1);
    check_vec("scalar_error", 64'(error_o), 64'd0);
    check_vec("scalar_out_drop", 64'(out_valid_o), 64'd0);
    tick();
    check_vec("scalar_done_pulse", 64'(done_o), 64'd0);
    check_vec("scalar_idle", 64'(cmd_ready_o), 64'd1);
  endtask

  initial begin
    logic [15:0] val;
    logic        lf;
    logic        le;
    rst = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_variable_index_i = '0;
    cmd_element_count_i = '0;
    chain_rsp_valid_i = 1'b0;
    chain_rsp_i = '0;
    out_ready_i = 1'b0;
    tick();
    tick();
    check_vec("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check_vec("rst_req", {63'd0, chain_req_valid_o} | chain_req_o, 64'd0);
    check_vec("rst_out_valid", 64'(out_valid_o), 64'd0);
    check_vec("rst_done_error", {62'd0, done_o, error_o}, 64'd0);
    rst = 1'b0;
    tick();

    scalar_read(16'd5, 16'hBEEF);

    // Two elements of two flits each, with a two-cycle stall on every output
    send_cmd(16'd2, 16'd2);
    for (int e = 0; e < 2; e++) begin
      for (int f = 0; f < 2; f++) begin
        val = 16'hA000 | 16'(e << 4) | 16'(f);
        lf  = (f == 1);
        le  = (e == 1) && (f == 1);
        serve(16'd2, 16'(e), 12'(f), 1'b0, lf, le, val);
        for (int s = 0; s < 2; s++) begin
          check_out("multi_stall", val, 16'(e), 12'(f), lf, le);
          tick();
        end
        check_out("multi_hs", val, 16'(e), 12'(f), lf, le);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
      end
    end
    check_vec("multi_done", 64'(done_o), 64'd1);
    check_vec("multi_error", 64'(error_o), 64'd0);
    tick();

    // Every response is a retry: four requests, then abort without output
    send_cmd(16'd7, 16'd1);
    for (int k = 0; k < 4; k++) begin
      serve(16'd7, 16'd0, 12'd0, 1'b1, 1'b0, 1'b0, 16'h5555);
      check_vec("retry_no_out", 64'(out_valid_o), 64'd0);
      check_vec("retry_state", {62'd0, done_o, chain_req_valid_o}, (k == 3) ? 64'd2 : 64'd1);
    end
    check_vec("retry_error", 64'(error_o), 64'd1);
    tick();
    check_vec("retry_error_sticky", 64'(error_o), 64'd1);

    // Timeout: the request leaves at the edge closing the request cycle; done follows 8 edges later
    send_cmd(16'd9, 16'd1);
    check_vec("tmo_error_cleared", 64'(error_o), 64'd0);
    check_vec("tmo_req", 64'(chain_req_valid_o), 64'd1);
    tick();
    for (int i = 1; i < 8; i++) begin
      chain_rsp_valid_i = (i <= 4);
      unique case (i)
        1: chain_rsp_i = iv(1'b1, 1'b0, 1'b1, 1'b1, 16'd8, 16'd0, 12'd0, 16'h1111);
        2: chain_rsp_i = iv(1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd0, 12'd1, 16'h2222);
        3: chain_rsp_i = iv(1'b0, 1'b0, 1'b1, 1'b1, 16'd9, 16'd0, 12'd0, 16'h3333);
        4: chain_rsp_i = iv(1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd1, 12'd0, 16'h4444);
        default: chain_rsp_i = iv(1'b1, 1'b0, 1'b1, 1'b1, 16'd9, 16'd0, 12'd0, 16'h9999);
      endcase
      tick();
      chain_rsp_valid_i = 1'b0;
      check_vec("tmo_not_yet", {62'd0, done_o, out_valid_o}, 64'd0);
    end
    tick();
    check_vec("tmo_done", 64'(done_o), 64'd1);
    check_vec("tmo_error", 64'(error_o), 64'd1);
    tick();

    // Reset while an output is held
    send_cmd(16'd3, 16'd1);
    serve(16'd3, 16'd0, 12'd0, 1'b0, 1'b1, 1'b1, 16'hCAFE);
    check_out("pre_rst", 16'hCAFE, 16'd0, 12'd0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_vec("mid_rst_ready", 64'(cmd_ready_o), 64'd1);
    check_vec("mid_rst_out", {14'd0, out_valid_o, out_data_o, out_element_index_o, out_flit_index_o,
                              out_last_flit_o, out_last_element_o}, 64'd0);
    check_vec("mid_rst_req", {63'd0, chain_req_valid_o} | chain_req_o, 64'd0);
    check_vec("mid_rst_done_error", {62'd0, done_o, error_o}, 64'd0);
    tick();
    rst = 1'b0;
    chain_rsp_valid_i = 1'b1;
    chain_rsp_i = iv(1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 16'd0, 12'd0, 16'hCAFE);
    tick();
    chain_rsp_valid_i = 1'b0;
    check_vec("post_rst_stale", {62'd0, out_valid_o, cmd_ready_o}, 64'd1);
    scalar_read(16'd4, 16'h1234);

    // Empty read
    send_cmd(16'd11, 16'd0);
    check_vec("zero_done", 64'(done_o), 64'd1);
    check_vec("zero_no_req", 64'(chain_req_valid_o), 64'd0);
    check_vec("zero_error", 64'(error_o), 64'd0);
    tick();
    check_vec("zero_idle", {62'd0, cmd_ready_o, chain_req_valid_o}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inspectable_read_sequencer.md
INSPECTABLE_READ_SEQUENCER -- requirements
Module: inspectable_read_sequencer

Interface
REQ-001 SHALL have parameter MAX_RETRIES, default 15: number of retry responses accepted per flit before abort.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent waiting for a response before abort.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 cmd_valid  in  1  read command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-008 cmd_variable_index  in  16  variable to read.
REQ-009 cmd_element_count  in  16  number of memory elements to read; 0 means none.
REQ-010 chain_req_valid  out  1  request strobe into the inspectable chain.
REQ-011 chain_req  out  64  InspectableValue request: valid, retry, last_flit, last_element and value all 0; variable_index, element_index and flit_index driven.
REQ-012 chain_rsp_valid  in  1  response strobe from the chain.
REQ-013 chain_rsp  in  64  InspectableValue response.
REQ-014 out_valid/out_ready  out/in  1/1  ready/valid result stream.
REQ-015 out_data  out  16  response value.
REQ-016 out_element_index  out  16  element the data belongs to.
REQ-017 out_flit_index  out  12  flit the data belongs to.
REQ-018 out_last_flit, out_last_element  out  1 each  copied from the response.
REQ-019 done  out  1  one-cycle pulse at command completion.
REQ-020 error  out  1  sticky abort flag; cleared on the next command accept.

Function
REQ-021 SHALL implement the states IDLE, ISSUE, WAIT, EMIT and DONE.
REQ-022 IDLE behaviour:
- cmd_ready=1 only in IDLE.
- On accept: latch variable index and count; clear element, flit, retry counter and error.
- Next state is ISSUE, or DONE if count==0.
REQ-023 ISSUE SHALL assert chain_req_valid for exactly one cycle with the current indices, clear the timeout counter, then go to WAIT.
REQ-024 WAIT behaviour:
- The timeout counter increments every cycle.
- A response is ignored unless chain_rsp_valid && rsp.valid && rsp.variable_index==latched index && rsp.element_index==current element && rsp.flit_index==current flit.
REQ-025 On a matching response with retry=1:
- If the retry counter equals MAX_RETRIES: set error and go to DONE.
- Otherwise: increment the counter and go to ISSUE.
REQ-026 On a matching response with retry=0: register value, last_flit and last_element, then go to EMIT.
REQ-027 If the timeout counter reaches TIMEOUT_CYCLES with no matching response, the block SHALL set error and go to DONE; a matching response arriving in the same cycle takes priority.
REQ-028 EMIT SHALL hold out_valid=1 with all out_* fields stable until out_ready; there is no combinational path from out_ready to out_valid.
REQ-029 On the EMIT handshake with last_flit=0:
- flit+1, retry counter cleared, go to ISSUE.
- If flit==4095, set error and go to DONE instead (no wrap-around).
REQ-030 On the EMIT handshake with last_flit=1:
- If last_element=1 or element+1==count: go to DONE.
- Otherwise: element+1, flit=0, retry counter cleared, go to ISSUE.
REQ-031 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-032 Latency: request to out_valid is 1 cycle after the matching response; at most one request is outstanding at any time.

Reset
REQ-033 Asserting rst at any time, including mid-command, SHALL immediately force IDLE and drive the following outputs:
- cmd_ready=1.
- chain_req_valid=0, chain_req=0.
- out_valid=0, all out_* fields 0.
- done=0, error=0.
- All counters 0.
REQ-034 No command state SHALL survive reset; a response arriving after reset is ignored.

Verification
REQ-035 Scalar read: var=5, count=1; response flit 0, last_flit=1, last_element=1, value 0xBEEF -> one output 0xBEEF with both last flags set, done pulse, error=0.
REQ-036 Multi-flit/multi-element read: var=2, count=2, two flits each, out_ready toggling -> four outputs in order (e0f0, e0f1, e1f0, e1f1), each held stable while stalled, then done.
REQ-037 Retry exhaustion: MAX_RETRIES=3, every response has retry=1 -> four requests issued, then error=1 and done; no output produced.
REQ-038 Timeout: TIMEOUT_CYCLES=8, no response -> error and done 8 cycles after the request; a stale or mismatched-index response is ignored.
REQ-039 Reset mid-EMIT with out_valid=1 -> all outputs at reset values; a new command afterwards completes normally.
REQ-040 count=0 -> no chain request, done one cycle after accept, error=0.
